// File: rtl/tk_host_status.sv
// Host-side status and run-control monitor: per-thread LED modes, sticky faults, run FSM, cycle counter.
// Define TK_STATUS_FAULT_STOP_EN to make any fault captured during RUN end the run.
module tk_host_status #(
  parameter int unsigned NUM_TRD    = 8,
  parameter int unsigned TRD_W      = 3,
  parameter int unsigned BLINK_W    = 16,
  parameter int unsigned FAST_SHIFT = 2,
  parameter int unsigned CYC_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         host_sig,
  input  logic [NUM_TRD-1:0] valid_trd,
  input  logic [NUM_TRD-1:0] running_trd,
  input  logic               running,
  input  logic               alu_exp,
  input  logic [TRD_W-1:0]   alu_trd,
  input  logic               inv_op,
  input  logic [TRD_W-1:0]   inv_op_trd,
  input  logic               i_segfault,
  input  logic [TRD_W-1:0]   i_trd,
  input  logic               d_segfault,
  input  logic [TRD_W-1:0]   d_trd,
  output logic [NUM_TRD-1:0] run_trd,
  output logic [NUM_TRD-1:0] fault_trd,
  output logic [CYC_W-1:0]   cycle,
  output logic               finish,
  output logic [1:0]         status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  state_e             state_q, state_d;
  logic [BLINK_W-1:0] blink_q;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic               finish_q, finish_d;
  logic [NUM_TRD-1:0] fault_q, fault_d, fault_hit;
  logic               seen_run_q, seen_run_d;
  logic [1:0]         idle_cnt_q, idle_cnt_d;
  logic               fault_stop;
  logic               slow_bit, fast_bit;

  // Decode a fault pulse to a thread mask; out-of-range indices match no bit.
  function automatic logic [NUM_TRD-1:0] trd_mask(input logic v, input logic [TRD_W-1:0] t);
    logic [NUM_TRD-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NUM_TRD; k++) begin
      if (v && (32'(t) == k)) m[k] = 1'b1;
    end
    return m;
  endfunction

  assign fault_hit = trd_mask(alu_exp, alu_trd) | trd_mask(inv_op, inv_op_trd) |
                     trd_mask(i_segfault, i_trd) | trd_mask(d_segfault, d_trd);

`ifdef TK_STATUS_FAULT_STOP_EN
  assign fault_stop = |fault_hit;
`else
  assign fault_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blink_q    <= '0;
      cycle_q    <= '0;
      finish_q   <= 1'b0;
      fault_q    <= '0;
      seen_run_q <= 1'b0;
      idle_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      blink_q    <= blink_q + BLINK_W'(1);
      cycle_q    <= cycle_d;
      finish_q   <= finish_d;
      fault_q    <= fault_d;
      seen_run_q <= seen_run_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Run FSM; clear overrides everything, then abort / auto-finish / fault stop.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    finish_d   = finish_q;
    fault_d    = fault_q | fault_hit;
    seen_run_d = seen_run_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        cycle_d  = '0;
        finish_d = 1'b0;
        if (host_sig == CMD_START) begin
          state_d    = ST_RUN;
          seen_run_d = 1'b0;
          idle_cnt_d = 2'd0;
        end
      end
      ST_RUN: begin
        if (running) begin
          seen_run_d = 1'b1;
          idle_cnt_d = 2'd0;
        end else if (seen_run_q) begin
          idle_cnt_d = idle_cnt_q + 2'd1;
        end
        // The transition edge does not advance cycle, so it freezes at the current count.
        if ((host_sig == CMD_ABORT) || (idle_cnt_d == 2'd2) || fault_stop) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
        end else if (cycle_q != {CYC_W{1'b1}}) begin
          cycle_d = cycle_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        finish_d = 1'b1;
        if (host_sig == CMD_START) begin
          state_d    = ST_RUN;
          cycle_d    = '0;
          finish_d   = 1'b0;
          seen_run_d = 1'b0;
          idle_cnt_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (host_sig == CMD_CLEAR) begin
      state_d  = ST_IDLE;
      cycle_d  = '0;
      finish_d = 1'b0;
      fault_d  = '0;
    end
  end

  assign slow_bit = blink_q[BLINK_W-1];
  assign fast_bit = blink_q[BLINK_W-1-FAST_SHIFT];

  // LED mode per thread: fault > running > allocated > off.
  always_comb begin
    run_trd = '0;
    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      if (fault_q[i])          run_trd[i] = fast_bit;
      else if (running_trd[i]) run_trd[i] = 1'b1;
      else if (valid_trd[i])   run_trd[i] = slow_bit;
      else                     run_trd[i] = 1'b0;
    end
  end

  assign fault_trd = fault_q;
  assign cycle     = cycle_q;
  assign finish    = finish_q;
  assign status    = state_q;

endmodule

// File: tb/tb_tk_host_status.sv
// Self-checking bench for tk_host_status: behavioural model compared every cycle plus directed literal checks.
module tb_tk_host_status;

  localparam int NT = 8;
  localparam int TW = 3;
  localparam int BW = 4;
  localparam int FS = 2;
  localparam int CW = 4;
  localparam int BLINK_P = 1 << BW;
  localparam int FAST_P  = BLINK_P >> FS;
  localparam int CYC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    host_sig = 2'b00;
  logic [NT-1:0] valid_trd = '0;
  logic [NT-1:0] running_trd = '0;
  logic          running = 1'b0;
  logic          alu_exp = 1'b0;
  logic [TW-1:0] alu_trd = '0;
  logic          inv_op = 1'b0;
  logic [TW-1:0] inv_op_trd = '0;
  logic          i_segfault = 1'b0;
  logic [TW-1:0] i_trd = '0;
  logic          d_segfault = 1'b0;
  logic [TW-1:0] d_trd = '0;
  logic [NT-1:0] run_trd;
  logic [NT-1:0] fault_trd;
  logic [CW-1:0] cycle;
  logic          finish;
  logic [1:0]    status;

  int checks = 0;
  int errors = 0;

  tk_host_status #(.NUM_TRD(NT), .TRD_W(TW), .BLINK_W(BW), .FAST_SHIFT(FS), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .host_sig(host_sig), .valid_trd(valid_trd), .running_trd(running_trd),
    .running(running), .alu_exp(alu_exp), .alu_trd(alu_trd), .inv_op(inv_op), .inv_op_trd(inv_op_trd),
    .i_segfault(i_segfault), .i_trd(i_trd), .d_segfault(d_segfault), .d_trd(d_trd),
    .run_trd(run_trd), .fault_trd(fault_trd), .cycle(cycle), .finish(finish), .status(status)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Model: 0 idle, 1 run, 2 done; time since reset drives the blink phases.
  bit            m_ok = 0;
  int            m_tick, m_state, m_cycle, m_quiet;
  bit            m_finish, m_seen, m_end;
  logic [NT-1:0] m_fault, m_hits;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_tick = 0; m_state = 0; m_cycle = 0; m_finish = 0;
      m_fault = '0; m_seen = 0; m_quiet = 0;
    end else begin
      m_tick++;
      m_hits = '0;
      if (alu_exp)    m_hits[alu_trd]    = 1'b1;
      if (inv_op)     m_hits[inv_op_trd] = 1'b1;
      if (i_segfault) m_hits[i_trd]      = 1'b1;
      if (d_segfault) m_hits[d_trd]      = 1'b1;
      if (host_sig == 2'b11) begin
        m_state = 0; m_cycle = 0; m_finish = 0; m_fault = '0;
      end else begin
        m_fault = m_fault | m_hits;
        if (m_state == 0 || m_state == 2) begin
          if (host_sig == 2'b01) begin
            m_state = 1; m_cycle = 0; m_finish = 0; m_seen = 0; m_quiet = 0;
          end
        end else begin
          if (running) begin m_seen = 1; m_quiet = 0; end
          else if (m_seen) m_quiet++;
          m_end = (host_sig == 2'b10) || (m_quiet == 2);
`ifdef TK_STATUS_FAULT_STOP_EN
          if (m_hits != '0) m_end = 1;
`endif
          if (m_end) begin m_state = 2; m_finish = 1; end
          else if (m_cycle < CYC_MAX) m_cycle++;
        end
      end
    end
  end

  function automatic logic [NT-1:0] exp_leds();
    logic [NT-1:0] l;
    bit slow, fast;
    slow = (m_tick % BLINK_P) >= (BLINK_P / 2);
    fast = (m_tick % FAST_P) >= (FAST_P / 2);
    for (int i = 0; i < NT; i++) begin
      if (m_fault[i])          l[i] = fast;
      else if (running_trd[i]) l[i] = 1'b1;
      else if (valid_trd[i])   l[i] = slow;
      else                     l[i] = 1'b0;
    end
    return l;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("run_trd",   32'(run_trd),   32'(exp_leds()));
      chk("fault_trd", 32'(fault_trd), 32'(m_fault));
      chk("cycle",     32'(cycle),     32'(m_cycle));
      chk("finish",    32'(finish),    32'(m_finish));
      chk("status",    32'(status),    32'(m_state));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and LED modes
    valid_trd = 8'h05; running_trd = 8'h01; rst = 1'b1;
    tick(2);
    chk("lit_rst_leds", 32'(run_trd), 32'h01);
    chk("lit_rst_status", 32'(status), 32'h0);
    chk("lit_rst_cycle", 32'(cycle), 32'h0);
    chk("lit_rst_finish", 32'(finish), 32'h0);
    chk("lit_rst_fault", 32'(fault_trd), 32'h0);
    rst = 1'b0;
    tick(8);
    chk("lit_slow_on", 32'(run_trd), 32'h05);
    tick(8);
    chk("lit_slow_off", 32'(run_trd), 32'h01);

    // Normal run with auto-finish two cycles after running falls
    host_sig = 2'b01; tick(1);
    host_sig = 2'b00; running = 1'b1; tick(10);
    running = 1'b0; tick(1);
    chk("lit_still_run", 32'(status), 32'h1);
    tick(1);
    chk("lit_done_status", 32'(status), 32'h2);
    chk("lit_done_finish", 32'(finish), 32'h1);
    chk("lit_done_cycle", 32'(cycle), 32'd11);
    host_sig = 2'b10; tick(3);
    host_sig = 2'b00;
    chk("lit_frozen_cycle", 32'(cycle), 32'd11);

    // Simultaneous faults, fast blink overrides running
    alu_exp = 1'b1; alu_trd = 3'd3; d_segfault = 1'b1; d_trd = 3'd3; inv_op = 1'b1; inv_op_trd = 3'd7;
    tick(1);
    alu_exp = 1'b0; d_segfault = 1'b0; inv_op = 1'b0;
    chk("lit_fault_88", 32'(fault_trd), 32'h88);
    running_trd = 8'hFF;
    tick(8);

    // Clear wins over a same-cycle fault pulse
    host_sig = 2'b11; alu_exp = 1'b1; alu_trd = 3'd2;
    tick(1);
    host_sig = 2'b00; alu_exp = 1'b0;
    chk("lit_clr_status", 32'(status), 32'h0);
    chk("lit_clr_cycle", 32'(cycle), 32'h0);
    chk("lit_clr_finish", 32'(finish), 32'h0);
    chk("lit_clr_fault", 32'(fault_trd), 32'h0);
    running_trd = 8'h01;

    // Abort in IDLE ignored; cycle saturation then abort
    host_sig = 2'b10; tick(2);
    chk("lit_abort_idle", 32'(status), 32'h0);
    host_sig = 2'b01; tick(1);
    host_sig = 2'b00; running = 1'b1; tick(20);
    chk("lit_sat_cycle", 32'(cycle), 32'hF);
    host_sig = 2'b01; tick(2);
    chk("lit_start_in_run", 32'(status), 32'h1);
    host_sig = 2'b10; tick(1);
    host_sig = 2'b00;
    chk("lit_abort_status", 32'(status), 32'h2);
    chk("lit_abort_cycle", 32'(cycle), 32'hF);

    // Restart from DONE, no running seen -> stays in RUN
    running = 1'b0; host_sig = 2'b01; tick(1);
    host_sig = 2'b00;
    chk("lit_restart_cycle", 32'(cycle), 32'h0);
    chk("lit_restart_finish", 32'(finish), 32'h0);
    tick(5);
    chk("lit_no_seen_run", 32'(status), 32'h1);

    // Fault during RUN
    host_sig = 2'b11; tick(1);
    host_sig = 2'b01; tick(1);
    host_sig = 2'b00; running = 1'b1; tick(5);
    inv_op = 1'b1; inv_op_trd = 3'd1; tick(1);
    inv_op = 1'b0;
    chk("lit_fs_fault", 32'(fault_trd), 32'h02);
`ifdef TK_STATUS_FAULT_STOP_EN
    chk("lit_fs_status", 32'(status), 32'h2);
    chk("lit_fs_cycle", 32'(cycle), 32'd5);
`else
    chk("lit_fs_status", 32'(status), 32'h1);
    chk("lit_fs_cycle", 32'(cycle), 32'd6);
`endif
    tick(3);

    // Reset mid-run
    host_sig = 2'b11; tick(1);
    host_sig = 2'b01; tick(1);
    host_sig = 2'b00; tick(3);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    chk("lit_rst_mid_status", 32'(status), 32'h0);
    chk("lit_rst_mid_cycle", 32'(cycle), 32'h0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tk_host_status.md
Name: tk_host_status

Overview:
- Parametrised host-side status and run-control monitor for the ThreadKraken board top.
- Sits between the host-interface registers and the CPU/MMU status nets.
- Generalises the single blink-counter LED logic to NUM_TRD threads, with four LED modes (off / slow blink / solid / fast blink).
- Adds sticky per-thread fault capture, a host-controlled run FSM, a saturating cycle counter and a finish flag.

Parameters:
- NUM_TRD, 8, number of hardware threads; LED and fault vectors are this wide.
- TRD_W, 3, width of thread-index inputs; must satisfy 2**TRD_W >= NUM_TRD.
- BLINK_W, 16, width of the free-running blink counter; slow blink = counter[BLINK_W-1].
- FAST_SHIFT, 2, fast blink = counter[BLINK_W-1-FAST_SHIFT]; must be < BLINK_W.
- CYC_W, 32, cycle counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- host_sig  in  2  host command: 00 nop, 01 start, 10 abort, 11 clear.
- valid_trd  in  NUM_TRD  thread allocated.
- running_trd  in  NUM_TRD  thread currently issuing.
- running  in  1  CPU has any thread running.
- alu_exp  in  1  ALU exception pulse.
- alu_trd  in  TRD_W  thread index for alu_exp.
- inv_op  in  1  invalid-opcode pulse.
- inv_op_trd  in  TRD_W  thread index for inv_op.
- i_segfault  in  1  instruction segfault pulse.
- i_trd  in  TRD_W  thread index for i_segfault.
- d_segfault  in  1  data segfault pulse.
- d_trd  in  TRD_W  thread index for d_segfault.
- run_trd  out  NUM_TRD  per-thread LED drive.
- fault_trd  out  NUM_TRD  sticky per-thread fault flags.
- cycle  out  CYC_W  run cycle count.
- finish  out  1  run complete.
- status  out  2  FSM state: 00 IDLE, 01 RUN, 10 DONE.

Behaviour:
- Reset: blink counter 0, FSM IDLE, cycle 0, finish 0, fault_trd 0, seen_run 0, idle_cnt 0.
- Reset output values: run_trd follows its mode rule, so it is 0 in the cycle after reset (counter = 0, no faults) except for bits whose running_trd input is high.
- All state is registered; run_trd is combinational from registers plus valid_trd/running_trd.
- Blink counter: free-running, increments every cycle in every state, wraps to 0.
- LED mode per thread i, priority order:
  - fault_trd[i] -> fast blink bit.
  - else running_trd[i] -> 1.
  - else valid_trd[i] -> slow blink bit.
  - else 0.
- Fault capture:
  - Each source pulse with thread index t < NUM_TRD sets fault_trd[t] on the next edge.
  - Simultaneous pulses OR together; several sources naming the same thread set a single bit.
  - Index >= NUM_TRD is ignored.
  - Capture is active in every state; bits clear only on rst or host_sig=11.
- IDLE:
  - cycle held at 0, finish 0.
  - host_sig=01 -> RUN; seen_run and idle_cnt cleared.
- RUN:
  - cycle = 0 in the first RUN cycle, then +1 per cycle; saturates at all-ones with no wrap.
  - seen_run sets when running=1.
  - idle_cnt counts consecutive cycles with seen_run=1 and running=0; any running=1 clears it.
  - idle_cnt reaching 2 -> DONE.
  - host_sig=10 -> DONE.
- DONE:
  - finish=1, cycle frozen.
  - host_sig=01 -> RUN: cycle restarts at 0, finish drops on the same edge.
- host_sig=11 in any state:
  - -> IDLE, cycle 0, finish 0, fault_trd 0.
  - A fault pulse in the same cycle is dropped; clear wins.
- host_sig=01 while in RUN is ignored. host_sig=10 in IDLE or DONE is ignored.
- Same-cycle priority: rst > clear > abort > auto-finish.
- rst mid-run returns everything to reset values on the next edge.

Optional Feature:
- Macro: TK_STATUS_FAULT_STOP_EN.
- Defined: any fault-set event while in RUN forces RUN -> DONE on the same edge the fault bit is set. cycle freezes at that cycle's count.
- Undefined: faults are recorded and shown on the LEDs only; the FSM ignores them.

Test Plan:
- rst, valid_trd=8'h05, running_trd=8'h01, BLINK_W=4 -> run_trd[0]=1 constant; run_trd[2] toggles every 8 cycles; other bits 0.
- host_sig=01 for 1 cycle, running=1 for 10 cycles then 0 -> status=10 two cycles after running falls; finish=1; cycle frozen at 11.
- Same cycle: alu_exp trd=3, d_segfault trd=3, inv_op trd=7 -> fault_trd=8'h88. run_trd[3] and run_trd[7] toggle at the fast rate even with running_trd=8'hFF.
- CYC_W=4, start, running held 1 for 20 cycles -> cycle saturates at 4'hF with no wrap; then abort (10) -> DONE with cycle=4'hF.
- In DONE with fault_trd=8'h88: drive host_sig=11 together with an alu_exp pulse -> next cycle status=00, cycle=0, finish=0, fault_trd=0.
- TK_STATUS_FAULT_STOP_EN defined: start, running=1, inv_op trd=1 at cycle 5 -> DONE with cycle=5 and fault_trd=8'h02. Undefined: same stimulus stays in RUN.
